// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences single read/write accesses and dump strobes to an
// asynchronous SRAM with programmable address setup and strobe widths.
// Latency: accept edge N -> done in cycle N+1+SETUP_CYCLES+STROBE_CYCLES
//          (writes add another SETUP_CYCLES+STROBE_CYCLES with verify enabled).
// Backpressure: busy is high outside IDLE; req/dump_req are ignored (not queued)
//          while busy, so the client holds a request until it is accepted.
// Optional feature macro: SRAM_CTRL_VERIFY_EN (write read-back verify).
//
// Ports:
//   clk, n_rst                 clock, asynchronous active-low reset
//   req, req_write, req_addr,  client access request, direction, address, data
//   req_data
//   dump_req, dump_num         client dump request and selector
//   busy, done                 not-idle flag, one-cycle completion pulse
//   rd_data                    last captured read data
//   verify_err                 write-verify mismatch flag (0 without verify)
//   sram_read, sram_write      SRAM strobes (never both high)
//   sram_addr, sram_data_out   SRAM address / write data, held through access
//   sram_data_in               SRAM read data
//   sram_dump, sram_dump_num   SRAM dump strobe and selector

module sram_access_ctrl #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic        dump_req,
  input  logic        dump_num,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        verify_err,
  output logic        sram_read,
  output logic        sram_write,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_data_out,
  input  logic [7:0]  sram_data_in,
  output logic        sram_dump,
  output logic        sram_dump_num
);

`ifdef SRAM_CTRL_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_DUMP, S_DONE, S_VSETUP, S_VSTROBE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_DUMP, S_DONE
  } state_t;
`endif

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_dir;           // latched direction: 1 = write
  logic [15:0] r_addr;
  logic [7:0]  r_data_out;
  logic [7:0]  r_rd_data;
  logic        r_dump_num;
  logic        w_accept;        // access request taken this edge
  logic        w_dump_accept;   // dump request taken this edge
  logic        w_strobe_last;   // final cycle of a client STROBE phase
  logic        w_verify_err;

  // Next-state logic: r_cnt counts cycles within the current timed phase.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_dump_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        // req has priority over dump_req when both are sampled together
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 4'd0;
        end else if (dump_req) begin
          w_dump_accept = 1'b1;
          w_state_nxt   = S_DUMP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == STROBE_LAST) begin
`ifdef SRAM_CTRL_VERIFY_EN
          w_state_nxt = r_dir ? S_VSETUP : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
          w_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
`ifdef SRAM_CTRL_VERIFY_EN
      S_VSETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_VSTROBE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_VSTROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
`endif
      S_DUMP:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_strobe_last = (r_state == S_STROBE) && (r_cnt == STROBE_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_dir      <= 1'b0;
      r_addr     <= 16'd0;
      r_data_out <= 8'd0;
      r_rd_data  <= 8'd0;
      r_dump_num <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_dir      <= req_write;
        r_addr     <= req_addr;
        r_data_out <= req_data;
      end
      if (w_dump_accept) begin
        r_dump_num <= dump_num;
      end
      if (w_strobe_last && !r_dir) begin
        r_rd_data <= sram_data_in;
      end
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic r_verify_err;

  // Compare on the last read-back cycle; the result lands as DONE is entered
  // and persists until the next write reaches DONE. Reads never touch it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_verify_err <= 1'b0;
    end else if ((r_state == S_VSTROBE) && (r_cnt == STROBE_LAST)) begin
      r_verify_err <= (sram_data_in != r_data_out);
    end
  end

  assign w_verify_err = r_verify_err;
  assign sram_read    = ((r_state == S_STROBE) && !r_dir) || (r_state == S_VSTROBE);
`else
  assign w_verify_err = 1'b0;
  assign sram_read    = (r_state == S_STROBE) && !r_dir;
`endif

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them in the same cycle.
  assign sram_write    = (r_state == S_STROBE) && r_dir;
  assign sram_dump     = (r_state == S_DUMP);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign rd_data       = r_rd_data;
  assign verify_err    = w_verify_err;
  assign sram_addr     = r_addr;
  assign sram_data_out = r_data_out;
  assign sram_dump_num = r_dump_num;

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: address/data setup cycles before each strobe; legal range 1-15.
REQ-002 Parameter STROBE_CYCLES, default 2: cycles each read/write strobe is held high; legal range 1-15.
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  system clock; all state updates on the rising edge.
REQ-005 Port n_rst  in  1  asynchronous active-low reset.
REQ-006 Port req  in  1  client access request; sampled only in IDLE.
REQ-007 Port req_write  in  1  access direction: 1 = write, 0 = read.
REQ-008 Port req_addr  in  16  client address.
REQ-009 Port req_data  in  8  client write data.
REQ-010 Port dump_req  in  1  client memory-dump request.
REQ-011 Port dump_num  in  1  dump selector, forwarded with the dump.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port done  out  1  one-cycle completion pulse.
REQ-014 Port rd_data  out  8  captured read data; held until the next read completes.
REQ-015 Port verify_err  out  1  write-verify mismatch flag (see Configuration).
REQ-016 Port sram_read  out  1  SRAM read strobe.
REQ-017 Port sram_write  out  1  SRAM write strobe.
REQ-018 Port sram_addr  out  16  SRAM address.
REQ-019 Port sram_data_out  out  8  SRAM write data.
REQ-020 Port sram_data_in  in  8  SRAM read data.
REQ-021 Port sram_dump  out  1  SRAM dump strobe.
REQ-022 Port sram_dump_num  out  1  SRAM dump selector.

Function
REQ-023 The FSM shall use states IDLE, SETUP, STROBE, DUMP and DONE, plus VSETUP and VSTROBE when verify is compiled in.
REQ-024 In IDLE with req=1 on edge N, the block shall latch req_addr, req_data and req_write into sram_addr, sram_data_out and the direction register, then enter SETUP.
REQ-025 SETUP shall last SETUP_CYCLES cycles with both strobes low and address/data stable.
REQ-026 STROBE shall last STROBE_CYCLES cycles with exactly one of sram_read or sram_write high, selected by the latched direction.
REQ-027 sram_addr and sram_data_out shall stay constant from the edge after N until DONE exits.
REQ-028 On the last STROBE cycle of a read, rd_data shall capture sram_data_in.
REQ-029 DONE shall last exactly one cycle with done=1, then return to IDLE.
REQ-030 Latency without verify: done=1 in cycle N+1+SETUP_CYCLES+STROBE_CYCLES (defaults: N+4).
REQ-031 sram_read and sram_write shall never be high in the same cycle, and shall be low in IDLE, SETUP, DONE and DUMP.
REQ-032 While busy=1, req and dump_req shall be ignored, with no queuing; the client holds a request until it is accepted.
REQ-033 If req and dump_req are both high in IDLE, req shall win; dump_req is serviced only when sampled with req=0.
REQ-034 An accepted dump_req shall latch dump_num into sram_dump_num, drive sram_dump=1 for exactly one cycle (DUMP), then enter DONE.
REQ-035 A back-to-back req (held high through DONE) shall be accepted on the first IDLE edge, giving at least two cycles (DONE, IDLE) of strobe-low between accesses.

Reset
REQ-036 n_rst=0 shall asynchronously force the FSM to IDLE and drive busy, done, rd_data, verify_err, sram_read, sram_write, sram_addr, sram_data_out, sram_dump and sram_dump_num to 0.
REQ-037 Reset asserted mid-strobe shall drop the strobe immediately, with no done pulse for the aborted access.

Configuration
REQ-038 With SRAM_CTRL_VERIFY_EN defined, each write STROBE shall be followed by VSETUP (SETUP_CYCLES) and VSTROBE (read strobe, STROBE_CYCLES) at the same address.
REQ-039 With verify compiled in, the read-back value shall be compared with sram_data_out on the last VSTROBE cycle, and verify_err shall be updated at DONE entry (1 = mismatch) and held until the next write's DONE.
REQ-040 With verify compiled in, write latency to done shall be N+1+2*(SETUP_CYCLES+STROBE_CYCLES), and rd_data shall not be modified by verify reads.
REQ-041 Without SRAM_CTRL_VERIFY_EN, the VSETUP/VSTROBE states and the comparator shall be absent and verify_err shall be tied to 0.

Verification
REQ-042 Write 89 to 0x0000, 210 to 0x003B, 66 to 0x00C3 using a behavioural SRAM -> each done at N+4 (defaults), sram_write high exactly 2 cycles each, sram_read never high.
REQ-043 Read 0x0000, 0x003B, 0x00C3 -> rd_data = 89, 210, 66 at each done; sram_read high exactly 2 cycles per access.
REQ-044 req=1 and dump_req=1 together in IDLE with dump_num=1 -> access serviced first; dump follows with sram_dump one cycle and sram_dump_num=1.
REQ-045 n_rst low in the second STROBE cycle of a write -> sram_write drops within the same cycle, no done pulse, all outputs 0; the next request completes normally.
REQ-046 SRAM_CTRL_VERIFY_EN with a model that corrupts address 0x003B -> write 210 there gives verify_err=1 at done (latency N+7); a following good write to 0x0000 clears it.
REQ-047 req pulsed while busy=1 -> ignored: no extra strobe, and done count equals the number of accepted requests.
